// File: rtl/random_access_checker_pkg.sv
// random_access_checker_pkg: shared FSM states and PRNG seed constants
package random_access_checker_pkg;
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FAIL} state_t;
   localparam logic [31:0] X0_INIT = 32'd12345678;
   localparam logic [31:0] X1_INIT = 32'd36243669;
   localparam logic [31:0] X2_INIT = 32'd521288629;
   localparam logic [31:0] X3_INIT = 32'd1481231;
endpackage

// File: rtl/random_access_checker_xorshift128_gen.sv
// xorshift128_gen: xorshift128 PRNG stepping once per cycle while advance is high
module xorshift128_gen
   import random_access_checker_pkg::*;
#(
   parameter logic [31:0] SEED = X3_INIT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        advance,
   output logic [31:0] x0
);
   logic [31:0] x1, x2, x3, s, t;
   assign s = x3 ^ (x3 << 11);
   assign t = s ^ (s >> 8);
   always_ff @(posedge clock) begin
      if (reset) begin
         x0 <= X0_INIT;
         x1 <= X1_INIT;
         x2 <= X2_INIT;
         x3 <= SEED;
      end else if (advance) begin
         x0 <= t ^ x0 ^ (x0 >> 19);
         x1 <= x0;
         x2 <= x1;
         x3 <= x2;
      end
   end
endmodule

// File: rtl/random_access_checker.sv
// random_access_checker: writes PRNG data to memory and checks each word back the following cycle
module random_access_checker
   import random_access_checker_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          ADDR_BITS   = 5,
   parameter int          TEST_SIZE   = 16,
   parameter logic [31:0] SEED        = X3_INIT,
   parameter bit          STOP_ON_ERR = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 inject_err,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          err_count,
   output logic [ADDR_BITS-1:0] first_err_addr,
   output logic [DATA_W-1:0]    first_err_exp,
   output logic [DATA_W-1:0]    first_err_got
);
   localparam logic [15:0] LAST = 16'(TEST_SIZE - 1);
   state_t state;
   logic [DATA_W-1:0] mem [2**ADDR_BITS];
   logic [31:0] x0;
   logic [15:0] cnt;
   logic vld_r, mismatch, stop, we, unused_bits;
   logic [ADDR_BITS-1:0] addr_r, waddr;
   logic [DATA_W-1:0] exp_r, wdata, rdata;
   xorshift128_gen #(.SEED(SEED)) u_prng (
      .clock  (clock),
      .reset  (reset),
      .advance(state == RUN),
      .x0     (x0)
   );
   assign unused_bits = ^x0;
   assign waddr = x0[ADDR_BITS-1:0];
   assign wdata = x0[DATA_W-1:0] ^ DATA_W'(inject_err);
   assign rdata = mem[addr_r];
   assign mismatch = vld_r && rdata != exp_r;
   assign stop = STOP_ON_ERR && mismatch;
   // a failing check squashes the write of the same cycle when stopping
   assign we = state == RUN && !stop && !reset;
   assign busy = state == RUN || state == DRAIN;
   assign done = state == DONE;
   assign pass = done && err_count == 16'd0;
   always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         vld_r <= 1'b0;
         addr_r <= '0;
         exp_r <= '0;
         err_count <= '0;
         first_err_addr <= '0;
         first_err_exp <= '0;
         first_err_got <= '0;
      end else begin
         vld_r <= we;
         if (we) begin
            addr_r <= waddr;
            exp_r <= x0[DATA_W-1:0];
         end
         if (mismatch) begin
            err_count <= err_count + 16'(err_count != 16'hFFFF);
            if (err_count == 16'd0) begin
               first_err_addr <= addr_r;
               first_err_exp <= exp_r;
               first_err_got <= rdata;
            end
         end
         case (state)
            IDLE, DONE, FAIL: if (start) begin
               state <= RUN;
               cnt <= '0;
               vld_r <= 1'b0;
               err_count <= '0;
               first_err_addr <= '0;
               first_err_exp <= '0;
               first_err_got <= '0;
            end
            RUN: begin
               cnt <= cnt + 16'd1;
               state <= stop ? FAIL : cnt == LAST ? DRAIN : RUN;
            end
            DRAIN: state <= stop ? FAIL : DONE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_random_access_checker.sv
// tb_random_access_checker: directed checks of the random access checker in three configurations
module tb_random_access_checker;
   logic clock = 1'b0, reset = 1'b1;
   logic start_a = 0, inj_a = 0, start_b = 0, inj_b = 0, start_c = 0, inj_c = 0;
   logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
   logic [15:0] err_a, err_b, err_c;
   logic [4:0] fa_a, fa_b;
   logic [0:0] fa_c;
   logic [15:0] fe_a, fg_a, fe_b, fg_b, fe_c, fg_c;
   int checks = 0, failures = 0, n;
   logic [31:0] g;
   always #5 clock = ~clock;
   random_access_checker dut_a (
      .clock(clock), .reset(reset), .start(start_a), .inject_err(inj_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
      .first_err_addr(fa_a), .first_err_exp(fe_a), .first_err_got(fg_a));
   random_access_checker #(.STOP_ON_ERR(0)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .inject_err(inj_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
      .first_err_addr(fa_b), .first_err_exp(fe_b), .first_err_got(fg_b));
   random_access_checker #(.ADDR_BITS(1), .TEST_SIZE(64)) dut_c (
      .clock(clock), .reset(reset), .start(start_c), .inject_err(inj_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
      .first_err_addr(fa_c), .first_err_exp(fe_c), .first_err_got(fg_c));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   // x0 of the reference xorshift128 after k steps from reset
   function automatic logic [31:0] gen(input int k);
      logic [31:0] a, b, c, d, t;
      a = 32'd12345678; b = 32'd36243669; c = 32'd521288629; d = 32'd1481231;
      for (int i = 0; i < k; i++) begin
         t = d ^ (d << 11);
         t = t ^ (t >> 8);
         t = t ^ a ^ (a >> 19);
         d = c; c = b; b = a; a = t;
      end
      return a;
   endfunction
   initial begin
      tick(); tick();
      reset = 0;
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_pass", pass_a, 0);
      check("rst_err", err_a, 0);
      check("rst_busy_b", busy_b, 0);
      check("rst_done_c", done_c, 0);
      // basic run with defaults
      start_a = 1; tick(); start_a = 0;
      n = 0;
      while (busy_a && n < 100) begin
         if (n == 0) begin
            check("w0_addr", dut_a.waddr, 14);
            check("w0_data", dut_a.wdata, 16'h614E);
         end
         if (n == 1) begin
            check("w1_addr", dut_a.waddr, 20);
            check("w1_data", dut_a.wdata, 16'h45B4);
         end
         n++; tick();
      end
      check("a_busy_cycles", n, 17);
      check("a_done", done_a, 1);
      check("a_pass", pass_a, 1);
      // single injected error on the third write, stop on error
      start_a = 1; tick(); start_a = 0;
      tick(); tick();
      inj_a = 1; tick(); inj_a = 0;
      check("b_chk_busy", busy_a, 1);
      check("b_chk_err", err_a, 0);
      tick();
      check("b_fail_busy", busy_a, 0);
      check("b_fail_done", done_a, 0);
      check("b_err", err_a, 1);
      g = gen(18);
      check("b_first_addr", fa_a, g[4:0]);
      check("b_first_exp", fe_a, g[15:0]);
      check("b_first_got", fg_a, g[15:0] ^ 16'h1);
      // reset mid-run, then reset beating a simultaneous start
      reset = 1; tick(); reset = 0;
      start_a = 1; tick(); start_a = 0;
      repeat (4) tick();
      check("c_mid_busy", busy_a, 1);
      reset = 1; tick(); reset = 0;
      check("c_abort_busy", busy_a, 0);
      check("c_abort_done", done_a, 0);
      reset = 1; start_a = 1; tick(); reset = 0;
      check("c_rst_start_busy", busy_a, 0);
      tick();
      check("c_w0_addr", dut_a.waddr, 14);
      check("c_w0_data", dut_a.wdata, 16'h614E);
      // start held high: one run, then immediate restart with continued PRNG
      n = 0;
      while (busy_a && n < 100) begin n++; tick(); end
      check("d_busy_cycles", n, 17);
      check("d_done", done_a, 1);
      check("d_pass", pass_a, 1);
      tick();
      start_a = 0;
      g = gen(16);
      check("d_restart_busy", busy_a, 1);
      check("d_restart_addr", dut_a.waddr, g[4:0]);
      check("d_restart_data", dut_a.wdata, g[15:0]);
      n = 0;
      while (busy_a && n < 100) begin n++; tick(); end
      check("d_pass2", pass_a, 1);
      // continue-on-error with every write corrupted
      reset = 1; tick(); reset = 0;
      inj_b = 1; start_b = 1; tick(); start_b = 0;
      n = 0;
      while (busy_b && n < 100) begin n++; tick(); end
      inj_b = 0;
      check("e_busy_cycles", n, 17);
      check("e_done", done_b, 1);
      check("e_pass", pass_b, 0);
      check("e_err", err_b, 16);
      check("e_first_addr", fa_b, 14);
      check("e_first_exp", fe_b, 16'h614E);
      check("e_first_got", fg_b, 16'h614F);
      // two-word memory forces back-to-back writes to the same address
      start_c = 1; tick(); start_c = 0;
      n = 0;
      while (busy_c && n < 200) begin n++; tick(); end
      check("f_busy_cycles", n, 65);
      check("f_done", done_c, 1);
      check("f_pass", pass_c, 1);
      check("f_err", err_c, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/random_access_checker.md
RANDOM_ACCESS_CHECKER -- requirements
Module: random_access_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width, legal range 1..32.
REQ-002 SHALL have parameter ADDR_BITS, default 5, memory depth 2**ADDR_BITS, legal range 1..16.
REQ-003 SHALL have parameter TEST_SIZE, default 16, writes per run, legal range 1..65535.
REQ-004 SHALL have parameter SEED, default 1481231, initial value of PRNG word x3.
REQ-005 SHALL have parameter STOP_ON_ERR, default 1; 1 = halt on first mismatch, 0 = count and continue.
REQ-006 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  begin a run; sampled only in IDLE, DONE or FAIL.
REQ-009 SHALL have port inject_err  input  1  while high in RUN, bit 0 of the word written to memory is inverted; expected value is unaffected.
REQ-010 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-011 SHALL have port done  output  1  high in DONE.
REQ-012 SHALL have port pass  output  1  done && err_count==0.
REQ-013 SHALL have port err_count  output  16  mismatches in current run, saturating at 16'hFFFF.
REQ-014 SHALL have port first_err_addr  output  ADDR_BITS  address of first mismatch in run.
REQ-015 SHALL have port first_err_exp  output  DATA_W  expected data of first mismatch.
REQ-016 SHALL have port first_err_got  output  DATA_W  read data of first mismatch.

Function
REQ-017 PRNG SHALL be xorshift128 with x0=12345678, x1=36243669, x2=521288629, x3=SEED; step: t=x3^(x3<<11); t^=t>>8; x0'=t^x0^(x0>>19); x3'=x2; x2'=x1; x1'=x0.
REQ-018 PRNG SHALL step exactly once per cycle in RUN and hold in all other states.
REQ-019 Each RUN cycle SHALL write mem[x0[ADDR_BITS-1:0]] <= x0[DATA_W-1:0] (bit 0 inverted if inject_err), using pre-step x0.
REQ-020 Each write SHALL register addr_r, exp_r (uninverted data) and vld_r=1; the check in the following cycle SHALL compare combinational mem[addr_r] against exp_r.
REQ-021 Consecutive writes to the same address SHALL check correctly: the check of write n reads the value of write n, not write n+1.
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN, DONE, FAIL.
REQ-023 IDLE/DONE/FAIL + start -> RUN; entry clears err_count, first_err_*, write counter and vld_r.
REQ-024 RUN SHALL advance to DRAIN in the cycle issuing write TEST_SIZE; DRAIN performs the last check and advances to DONE.
REQ-025 A mismatch SHALL increment err_count (saturating) and capture first_err_* only when err_count==0.
REQ-026 With STOP_ON_ERR=1 a mismatch SHALL move to FAIL on the next edge, suppressing the write of that cycle; with 0 the run continues.
REQ-027 start while busy SHALL be ignored; restart from DONE/FAIL SHALL continue the PRNG sequence without reseeding.
REQ-028 Total latency start-sampled to done SHALL be TEST_SIZE+1 cycles of busy followed by done.

Reset
REQ-029 reset SHALL force IDLE, reload PRNG to REQ-017 values, clear vld_r, counter, err_count and first_err_*; busy=done=pass=0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 reset mid-run SHALL abort immediately to IDLE; reset overrides a simultaneous start.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the four PRNG initial constants.
REQ-033 The PRNG SHALL be a sub-module xorshift128_gen with an advance enable, sync reset and 32-bit x0 output.

Verification
REQ-034 Defaults, reset, start pulse -> first write addr 14 data 16'h614E, second addr 20 data 16'h45B4; done after 17 busy cycles, pass=1.
REQ-035 inject_err high on 3rd RUN cycle only, STOP_ON_ERR=1 -> FAIL one cycle after the check, err_count=1, first_err_got = first_err_exp ^ 1.
REQ-036 STOP_ON_ERR=0, inject_err high for whole run -> DONE, err_count=16, pass=0, first_err_addr=14, first_err_exp=16'h614E.
REQ-037 ADDR_BITS=1, TEST_SIZE=64 -> forced same-address back-to-back writes, pass=1.
REQ-038 reset asserted on 5th RUN cycle, then start -> first write again addr 14 data 16'h614E, pass=1.
REQ-039 start held high through an entire run -> exactly one run, immediate restart from DONE, second run uses continued PRNG values.
